reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard.sv | 108 ++++++++++
 tb/tb_reg_scoreboard.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Dual-issue register scoreboard: tracks pending writes with per-register latency counters
// and decides how many of the two decoded instructions may issue this cycle.
module reg_scoreboard (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid1,
  input  logic        id_valid2,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rt1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rt2,
  input  logic        id_use_rs1,
  input  logic        id_use_rt1,
  input  logic        id_use_rs2,
  input  logic        id_use_rt2,
  input  logic        id_wen1,
  input  logic        id_wen2,
  input  logic [4:0]  id_waddr1,
  input  logic [4:0]  id_waddr2,
  input  logic [2:0]  id_lat1,
  input  logic [2:0]  id_lat2,
  input  logic        pipe_hold,
  input  logic        flush,
  input  logic        lpu_done,
  input  logic [4:0]  lpu_waddr,
  output logic [1:0]  issue_num,
  output logic        id_stall,
  output logic [31:0] busy_vec
);

  localparam logic [2:0] LatUnbounded = 3'd7;

  logic [31:0] pend_q, pend_d;
  logic [2:0]  cnt_q [32];
  logic [2:0]  cnt_d [32];

  logic haz1, haz2, dep2, issue1, issue2;

  always_comb begin
    haz1 = (id_use_rs1 && (id_rs1 != 5'd0) && pend_q[id_rs1]) ||
           (id_use_rt1 && (id_rt1 != 5'd0) && pend_q[id_rt1]) ||
           (id_wen1 && (id_waddr1 != 5'd0) && pend_q[id_waddr1]);
    haz2 = (id_use_rs2 && (id_rs2 != 5'd0) && pend_q[id_rs2]) ||
           (id_use_rt2 && (id_rt2 != 5'd0) && pend_q[id_rt2]) ||
           (id_wen2 && (id_waddr2 != 5'd0) && pend_q[id_waddr2]);
    // Slot2 may not consume or overwrite what slot1 produces in the same bundle
    dep2 = id_wen1 && (id_waddr1 != 5'd0) &&
           ((id_use_rs2 && (id_rs2 == id_waddr1)) ||
            (id_use_rt2 && (id_rt2 == id_waddr1)) ||
            (id_wen2 && (id_waddr2 == id_waddr1)));
    issue1 = id_valid1 && !pipe_hold && !flush && !rst && !haz1;
    issue2 = issue1 && id_valid2 && !haz2 && !dep2;
    if (issue2) begin
      issue_num = 2'd2;
    end else if (issue1) begin
      issue_num = 2'd1;
    end else begin
      issue_num = 2'd0;
    end
    id_stall = id_valid1 && (issue_num == 2'd0);
  end

  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    for (int unsigned r = 1; r < 32; r++) begin
      if (pend_q[r]) begin
        if (cnt_q[r] == LatUnbounded) begin
          if (lpu_done && (lpu_waddr == r[4:0])) begin
            pend_d[r] = 1'b0;
            cnt_d[r]  = 3'd0;
          end
        end else if (!pipe_hold) begin
          cnt_d[r] = cnt_q[r] - 3'd1;
          if (cnt_q[r] == 3'd1) begin
            pend_d[r] = 1'b0;
          end
        end
      end
      // A fresh issue overrides any decrement or completion on the same register
      if (issue1 && id_wen1 && (id_waddr1 == r[4:0])) begin
        pend_d[r] = (id_lat1 != 3'd0);
        cnt_d[r]  = id_lat1;
      end
      if (issue2 && id_wen2 && (id_waddr2 == r[4:0])) begin
        pend_d[r] = (id_lat2 != 3'd0);
        cnt_d[r]  = id_lat2;
      end
    end
    pend_d[0] = 1'b0;
    cnt_d[0]  = 3'd0;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pend_q <= '0;
      for (int unsigned r = 0; r < 32; r++) begin
        cnt_q[r] <= 3'd0;
      end
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_vec = pend_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized and directed checks of reg_scoreboard against a per-register
// "cycles remaining" reference model.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid1, id_valid2;
  logic [4:0]  id_rs1, id_rt1, id_rs2, id_rt2;
  logic        id_use_rs1, id_use_rt1, id_use_rs2, id_use_rt2;
  logic        id_wen1, id_wen2;
  logic [4:0]  id_waddr1, id_waddr2;
  logic [2:0]  id_lat1, id_lat2;
  logic        pipe_hold, flush, lpu_done;
  logic [4:0]  lpu_waddr;
  logic [1:0]  issue_num;
  logic        id_stall;
  logic [31:0] busy_vec;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  // Model: remaining[r] = 0 free, 1..6 cycles to go, 7 waits for lpu_done
  int remaining [32];

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid1  (id_valid1),
    .id_valid2  (id_valid2),
    .id_rs1     (id_rs1),
    .id_rt1     (id_rt1),
    .id_rs2     (id_rs2),
    .id_rt2     (id_rt2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rt1 (id_use_rt1),
    .id_use_rs2 (id_use_rs2),
    .id_use_rt2 (id_use_rt2),
    .id_wen1    (id_wen1),
    .id_wen2    (id_wen2),
    .id_waddr1  (id_waddr1),
    .id_waddr2  (id_waddr2),
    .id_lat1    (id_lat1),
    .id_lat2    (id_lat2),
    .pipe_hold  (pipe_hold),
    .flush      (flush),
    .lpu_done   (lpu_done),
    .lpu_waddr  (lpu_waddr),
    .issue_num  (issue_num),
    .id_stall   (id_stall),
    .busy_vec   (busy_vec)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit busy(input logic [4:0] r);
    return (r != 5'd0) && (remaining[r] != 0);
  endfunction

  function automatic int model_issue();
    bit ok1, ok2;
    ok1 = id_valid1 && !pipe_hold && !flush && !rst &&
          !(id_use_rs1 && busy(id_rs1)) && !(id_use_rt1 && busy(id_rt1)) &&
          !(id_wen1 && busy(id_waddr1));
    ok2 = ok1 && id_valid2 &&
          !(id_use_rs2 && busy(id_rs2)) && !(id_use_rt2 && busy(id_rt2)) &&
          !(id_wen2 && busy(id_waddr2));
    if (ok2 && id_wen1 && id_waddr1 != 5'd0 &&
        ((id_use_rs2 && id_rs2 == id_waddr1) || (id_use_rt2 && id_rt2 == id_waddr1) ||
         (id_wen2 && id_waddr2 == id_waddr1)))
      ok2 = 1'b0;
    return ok2 ? 2 : (ok1 ? 1 : 0);
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] v = '0;
    for (int r = 1; r < 32; r++) v[r] = (remaining[r] != 0);
    return v;
  endfunction

  task automatic clear_in();
    {id_valid1, id_valid2, id_use_rs1, id_use_rt1, id_use_rs2, id_use_rt2} = '0;
    {id_rs1, id_rt1, id_rs2, id_rt2, id_waddr1, id_waddr2, lpu_waddr} = '0;
    {id_wen1, id_wen2, pipe_hold, flush, lpu_done, rst} = '0;
    id_lat1 = 3'd0;
    id_lat2 = 3'd0;
  endtask

  // Check outputs for the current inputs, then advance one cycle and update the model
  task automatic step();
    int n;
    #1;
    n = model_issue();
    check("issue_num", 32'(issue_num), n);
    if (!rst) check("id_stall", 32'(id_stall), 32'(id_valid1 && n == 0));
    if (started) check("busy_vec", busy_vec, model_busy());
    @(posedge clk);
    if (rst || flush) begin
      for (int r = 0; r < 32; r++) remaining[r] = 0;
      started = 1'b1;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (remaining[r] == 7) begin
          if (lpu_done && lpu_waddr == r[4:0]) remaining[r] = 0;
        end else if (remaining[r] > 0 && !pipe_hold) begin
          remaining[r] = remaining[r] - 1;
        end
      end
      if (n >= 1 && id_wen1 && id_waddr1 != 5'd0) remaining[id_waddr1] = int'(id_lat1);
      if (n == 2 && id_wen2 && id_waddr2 != 5'd0) remaining[id_waddr2] = int'(id_lat2);
    end
    @(negedge clk);
  endtask

  task automatic expect_now(input string tag, input logic [31:0] got, input logic [31:0] exp);
    #1;
    check(tag, got, exp);
  endtask

  task automatic put1(input logic [4:0] wa, input logic [2:0] lat);
    id_valid1 = 1'b1;
    id_wen1   = 1'b1;
    id_waddr1 = wa;
    id_lat1   = lat;
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    @(negedge clk);
    step();
    step();
    clear_in();
    check("reset_busy", busy_vec, 32'h0);

    // Load-use: two stall cycles, issue on the third
    put1(5'd5, 3'd2);
    step();
    clear_in();
    id_valid1 = 1'b1; id_use_rs1 = 1'b1; id_rs1 = 5'd5;
    expect_now("lu_stall0", 32'(id_stall), 32'd1);
    step();
    expect_now("lu_stall1", 32'(id_stall), 32'd1);
    step();
    expect_now("lu_issue", 32'(issue_num), 32'd1);
    step();
    clear_in();

    // Intra-bundle dependence
    put1(5'd3, 3'd0);
    id_valid2 = 1'b1; id_use_rs2 = 1'b1; id_rs2 = 5'd3;
    expect_now("intra_one", 32'(issue_num), 32'd1);
    step();
    clear_in();
    id_valid1 = 1'b1; id_use_rs1 = 1'b1; id_rs1 = 5'd3;
    expect_now("intra_next", 32'(issue_num), 32'd1);
    step();
    clear_in();

    // Divider stays busy until its completion
    put1(5'd8, 3'd7);
    step();
    clear_in();
    for (int i = 0; i < 20; i++) begin
      pipe_hold = (i % 3 == 0);
      expect_now("div_busy", 32'(busy_vec[8]), 32'd1);
      step();
    end
    clear_in();
    lpu_done = 1'b1; lpu_waddr = 5'd8;
    step();
    clear_in();
    expect_now("div_done", 32'(busy_vec[8]), 32'd0);
    lpu_done = 1'b1; lpu_waddr = 5'd8;
    step();
    clear_in();

    // pipe_hold freezes the count
    put1(5'd10, 3'd3);
    step();
    clear_in();
    pipe_hold = 1'b1;
    put1(5'd11, 3'd1);
    for (int i = 0; i < 4; i++) begin
      expect_now("hold_issue", 32'(issue_num), 32'd0);
      step();
    end
    clear_in();
    step();
    step();
    expect_now("hold_last", 32'(busy_vec[10]), 32'd1);
    step();
    expect_now("hold_clear", 32'(busy_vec[10]), 32'd0);

    // Flush wipes pending entries including unbounded ones
    put1(5'd4, 3'd5);
    id_valid2 = 1'b1; id_wen2 = 1'b1; id_waddr2 = 5'd9; id_lat2 = 3'd7;
    step();
    clear_in();
    put1(5'd12, 3'd2);
    flush = 1'b1;
    pipe_hold = 1'b1;
    expect_now("flush_issue", 32'(issue_num), 32'd0);
    step();
    clear_in();
    expect_now("flush_busy", busy_vec, 32'h0);

    // Writes to r0 are never recorded
    put1(5'd0, 3'd3);
    step();
    clear_in();
    expect_now("r0_busy", busy_vec, 32'h0);

    // Mid-operation reset with an unbounded entry, then a stale completion
    put1(5'd6, 3'd7);
    step();
    clear_in();
    rst = 1'b1;
    step();
    clear_in();
    lpu_done = 1'b1; lpu_waddr = 5'd6;
    expect_now("rst_mid", busy_vec, 32'h0);
    step();
    clear_in();

    // Random traffic on a small register window to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      id_valid1  = ($urandom_range(0, 9) < 8);
      id_valid2  = ($urandom_range(0, 9) < 7);
      id_rs1     = 5'($urandom_range(0, 7));
      id_rt1     = 5'($urandom_range(0, 7));
      id_rs2     = 5'($urandom_range(0, 7));
      id_rt2     = 5'($urandom_range(0, 7));
      id_use_rs1 = 1'($urandom);
      id_use_rt1 = 1'($urandom);
      id_use_rs2 = 1'($urandom);
      id_use_rt2 = 1'($urandom);
      id_wen1    = 1'($urandom);
      id_wen2    = 1'($urandom);
      id_waddr1  = 5'($urandom_range(0, 7));
      id_waddr2  = 5'($urandom_range(0, 7));
      id_lat1    = 3'($urandom);
      id_lat2    = 3'($urandom);
      pipe_hold  = ($urandom_range(0, 9) < 2);
      flush      = ($urandom_range(0, 49) == 0);
      rst        = ($urandom_range(0, 199) == 0);
      lpu_done   = ($urandom_range(0, 3) == 0);
      lpu_waddr  = 5'($urandom_range(0, 7));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
